// File: rtl/dp_pkg.sv
// Shared datapath definitions for the PE output-buffer reader and input-side writer.
// Holds bus widths, default lane geometry and the common frame state encoding.
package dp_pkg;

  localparam int OUT_WIDTH      = 32;
  localparam int PSUM_WIDTH_DEF = 16;
  localparam int OUTBUF_PAR_DEF = 2;
  localparam int CNT_WIDTH_DEF  = 16;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    WAIT  = 3'd2,
    SEND  = 3'd3,
    DONE  = 3'd4
  } dp_state_e;

  // Lane index width; a single-lane buffer still gets a 1-bit index.
  function automatic int idx_width(input int lanes);
    return (lanes > 1) ? $clog2(lanes) : 1;
  endfunction

endpackage

// File: rtl/psum_outbuf_reader_if.sv
// Buffer-pop and output-stream bundle of the psum output-buffer reader.
// master = the reader, slave = buffer plus downstream consumer.
interface psum_outbuf_reader_if #(
  parameter int PAR    = 2,
  parameter int PSUM_W = 16
);
  import dp_pkg::*;

  logic                    buf_empty;
  logic                    buf_rd_en;
  logic [PAR*PSUM_W-1:0]   buf_rd_data;
  logic [OUT_WIDTH-1:0]    outData;
  logic                    out_valid;
  logic                    out_ready;

  modport master (
    output buf_rd_en,
    output outData,
    output out_valid,
    input  buf_empty,
    input  buf_rd_data,
    input  out_ready
  );

  modport slave (
    input  buf_rd_en,
    input  outData,
    input  out_valid,
    output buf_empty,
    output buf_rd_data,
    output out_ready
  );

endinterface

// File: rtl/psum_lane_sel.sv
// Holds one popped lane group, steps through its lanes and sign-extends the
// selected psum onto the 32-bit output bus.
module psum_lane_sel
  import dp_pkg::*;
#(
  parameter  int PAR    = OUTBUF_PAR_DEF,
  parameter  int PSUM_W = PSUM_WIDTH_DEF,
  localparam int IDX_W  = idx_width(PAR)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_i,
  input  logic                  advance_i,
  input  logic [PAR*PSUM_W-1:0] lanes_i,
  output logic [OUT_WIDTH-1:0]  data_o,
  output logic                  last_o
);

  logic [PAR*PSUM_W-1:0] lane_q;
  logic [IDX_W-1:0]      idx_q;
  logic [PSUM_W-1:0]     lane_arr [PAR];
  logic [PSUM_W-1:0]     psum_sel;

  for (genvar gi = 0; gi < PAR; gi++) begin : g_unpack
    assign lane_arr[gi] = lane_q[gi*PSUM_W +: PSUM_W];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lane_q <= '0;
      idx_q  <= '0;
    end else if (load_i) begin
      lane_q <= lanes_i;
      idx_q  <= '0;
    end else if (advance_i) begin
      idx_q  <= idx_q + IDX_W'(1);
    end
  end

  // Priority-free mux written as a loop so non-power-of-two lane counts stay in range.
  always_comb begin
    psum_sel = lane_arr[0];
    for (int i = 1; i < PAR; i++) begin
      if (idx_q == IDX_W'(i)) psum_sel = lane_arr[i];
    end
  end

  assign last_o = (idx_q == IDX_W'(PAR - 1));

  if (PSUM_W < OUT_WIDTH) begin : g_sext
    assign data_o = {{(OUT_WIDTH - PSUM_W){psum_sel[PSUM_W-1]}}, psum_sel};
  end else begin : g_full
    assign data_o = psum_sel;
  end

endmodule

// File: rtl/psum_outbuf_reader.sv
// Drains the PE output buffer one lane group per pop and streams the psums one
// per beat on a valid/ready bus; one frame of cfg_count psums per start pulse.
module psum_outbuf_reader
  import dp_pkg::*;
#(
  parameter int OUTBUF_PAR_READ  = OUTBUF_PAR_DEF,
  parameter int INPUT_PSUM_WIDTH = PSUM_WIDTH_DEF,
  parameter int CNT_WIDTH        = CNT_WIDTH_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [CNT_WIDTH-1:0] cfg_count,
  output logic                 busy,
  output logic                 done,
  psum_outbuf_reader_if.master bus
);

  dp_state_e            state_q, state_d;
  logic [CNT_WIDTH-1:0] remaining_q, remaining_d;
  logic                 load_lane;
  logic                 advance_lane;
  logic                 last_lane;
  logic                 rd_en;
  logic                 valid;

  psum_lane_sel #(
    .PAR    (OUTBUF_PAR_READ),
    .PSUM_W (INPUT_PSUM_WIDTH)
  ) u_lane_sel (
    .clk       (clk),
    .rst       (rst),
    .load_i    (load_lane),
    .advance_i (advance_lane),
    .lanes_i   (bus.buf_rd_data),
    .data_o    (bus.outData),
    .last_o    (last_lane)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      remaining_q <= '0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    remaining_d  = remaining_q;
    rd_en        = 1'b0;
    valid        = 1'b0;
    load_lane    = 1'b0;
    advance_lane = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          remaining_d = cfg_count;
          state_d     = (cfg_count == '0) ? DONE : FETCH;
        end
      end
      FETCH: begin
        rd_en = !bus.buf_empty;
        if (!bus.buf_empty) state_d = WAIT;
      end
      // Buffer returns data one cycle after the pop.
      WAIT: begin
        load_lane = 1'b1;
        state_d   = SEND;
      end
      SEND: begin
        valid = 1'b1;
        if (bus.out_ready) begin
          advance_lane = 1'b1;
          remaining_d  = remaining_q - CNT_WIDTH'(1);
          if (remaining_q == CNT_WIDTH'(1)) begin
            state_d = DONE;
          end else if (last_lane) begin
            state_d = FETCH;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs decode the registered state only, so out_ready never reaches out_valid.
  assign bus.buf_rd_en = rd_en;
  assign bus.out_valid = valid;
  assign busy          = (state_q == FETCH) || (state_q == WAIT) || (state_q == SEND);
  assign done          = (state_q == DONE);

endmodule

// File: tb/tb_psum_outbuf_reader.sv
// Directed bench for psum_outbuf_reader: buffer model, beat capture and
// immediate-assertion checks against hand-computed values.
module tb_psum_outbuf_reader;
  import dp_pkg::*;

  localparam int PAR = 2;
  localparam int W   = 16;
  localparam int CW  = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [CW-1:0] cfg_count;
  logic          busy;
  logic          done;

  psum_outbuf_reader_if #(.PAR(PAR), .PSUM_W(W)) bus ();

  psum_outbuf_reader #(
    .OUTBUF_PAR_READ  (PAR),
    .INPUT_PSUM_WIDTH (W),
    .CNT_WIDTH        (CW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .cfg_count (cfg_count),
    .busy      (busy),
    .done      (done),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  logic [31:0] buf_mem [64];
  logic [31:0] beat_mem [256];
  int          wr_ptr = 0;
  int          rd_ptr = 0;
  int          pop_cnt = 0;
  int          bad_pops = 0;
  int          done_cnt = 0;
  int          beat_cnt = 0;
  logic        force_empty;
  int          checks = 0;
  int          failures = 0;
  int          b0, p0, d0;

  always_comb bus.buf_empty = force_empty || (rd_ptr == wr_ptr);

  always @(posedge clk) begin
    if (bus.buf_rd_en) begin
      if (bus.buf_empty) bad_pops <= bad_pops + 1;
      bus.buf_rd_data <= buf_mem[rd_ptr[5:0]];
      rd_ptr          <= rd_ptr + 1;
      pop_cnt         <= pop_cnt + 1;
    end
    if (bus.out_valid && bus.out_ready) begin
      beat_mem[beat_cnt[7:0]] <= bus.outData;
      beat_cnt                <= beat_cnt + 1;
    end
    if (done) done_cnt <= done_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] w);
    buf_mem[wr_ptr[5:0]] = w;
    wr_ptr++;
  endtask

  // Runs until done, then checks done came one cycle after the last accepted beat and lasts one cycle.
  task automatic wait_done(input string tag, input int max_cyc);
    int last_acc;
    int cyc;
    bit seen;
    last_acc = -100;
    cyc      = 0;
    seen     = 1'b0;
    while (!seen && cyc < max_cyc) begin
      if (bus.out_valid && bus.out_ready) last_acc = cyc;
      if (done) seen = 1'b1;
      else begin
        tick();
        cyc++;
      end
    end
    check({tag, " done_seen"}, 32'(seen), 32'd1);
    if (seen) begin
      check({tag, " done_after_last_beat"}, 32'(cyc - last_acc), 32'd1);
      tick();
      check({tag, " done_one_cycle"}, 32'(done), 32'd0);
      check({tag, " busy_after_done"}, 32'(busy), 32'd0);
    end
  endtask

  task automatic check_frame(input string tag, input int exp_pops, input int n,
                             input logic [31:0] e0, input logic [31:0] e1,
                             input logic [31:0] e2, input logic [31:0] e3);
    logic [31:0] ev [4];
    ev[0] = e0; ev[1] = e1; ev[2] = e2; ev[3] = e3;
    check({tag, " beats"}, 32'(beat_cnt - b0), 32'(n));
    check({tag, " pops"}, 32'(pop_cnt - p0), 32'(exp_pops));
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s beat%0d", tag, i), beat_mem[8'(b0 + i)], ev[i]);
    end
    $display("frame %s: beats=%0d pops=%0d", tag, beat_cnt - b0, pop_cnt - p0);
  endtask

  task automatic mark();
    b0 = beat_cnt;
    p0 = pop_cnt;
    d0 = done_cnt;
  endtask

  initial begin
    rst           = 1'b1;
    start         = 1'b0;
    cfg_count     = '0;
    force_empty   = 1'b0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst out_valid", 32'(bus.out_valid), 32'd0);
    check("rst buf_rd_en", 32'(bus.buf_rd_en), 32'd0);
    check("rst busy", 32'(busy), 32'd0);
    check("rst done", 32'(done), 32'd0);
    check("rst outData", bus.outData, 32'd0);
    rst = 1'b0;
    tick();

    // Full frame: two groups, latency and done timing.
    push(32'h0002_0001);
    push(32'hFFFF_0003);
    mark();
    start = 1'b1; cfg_count = 16'd4;
    tick();
    start = 1'b0;
    check("t1 busy", 32'(busy), 32'd1);
    check("t1 rd_en fetch", 32'(bus.buf_rd_en), 32'd1);
    check("t1 valid fetch", 32'(bus.out_valid), 32'd0);
    tick();
    check("t1 valid wait", 32'(bus.out_valid), 32'd0);
    check("t1 rd_en wait", 32'(bus.buf_rd_en), 32'd0);
    tick();
    check("t1 first valid", 32'(bus.out_valid), 32'd1);
    check("t1 first data", bus.outData, 32'd1);
    wait_done("t1", 40);
    check_frame("t1", 2, 4, 32'd1, 32'd2, 32'd3, 32'hFFFF_FFFF);

    // Partial last group: lane1 of second pop discarded.
    push(32'h0002_0001);
    push(32'hFFFF_0003);
    mark();
    start = 1'b1; cfg_count = 16'd3;
    tick();
    start = 1'b0;
    wait_done("t2", 40);
    check_frame("t2", 2, 3, 32'd1, 32'd2, 32'd3, 32'd0);

    // Backpressure mid-frame.
    push(32'h0002_0001);
    push(32'hFFFF_0003);
    mark();
    start = 1'b1; cfg_count = 16'd4;
    tick();
    start = 1'b0;
    repeat (3) tick();
    check("t3 second beat", bus.outData, 32'd2);
    bus.out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("t3 hold valid c%0d", i), 32'(bus.out_valid), 32'd1);
      check($sformatf("t3 hold data c%0d", i), bus.outData, 32'd2);
    end
    check("t3 no extra pop", 32'(pop_cnt - p0), 32'd1);
    bus.out_ready = 1'b1;
    wait_done("t3", 40);
    check_frame("t3", 2, 4, 32'd1, 32'd2, 32'd3, 32'hFFFF_FFFF);

    // Buffer empty after start, then released.
    force_empty = 1'b1;
    push(32'h0002_0001);
    mark();
    start = 1'b1; cfg_count = 16'd2;
    tick();
    start = 1'b0;
    check("t4 busy while empty", 32'(busy), 32'd1);
    for (int i = 0; i < 10; i++) begin
      check($sformatf("t4 stalled c%0d", i), {30'd0, bus.buf_rd_en, bus.out_valid}, 32'd0);
      tick();
    end
    force_empty = 1'b0;
    #1;
    check("t4 rd_en on release", 32'(bus.buf_rd_en), 32'd1);
    tick();
    check("t4 valid after pop", 32'(bus.out_valid), 32'd0);
    tick();
    check("t4 valid 2 after pop", 32'(bus.out_valid), 32'd1);
    check("t4 first data", bus.outData, 32'd1);
    wait_done("t4", 40);
    check_frame("t4", 1, 2, 32'd1, 32'd2, 32'd0, 32'd0);

    // Zero-length frame, then a frame with an ignored start while busy.
    push(32'h8000_7FFF);
    mark();
    start = 1'b1; cfg_count = 16'd0;
    tick();
    start = 1'b0;
    check("t5 zero done", 32'(done), 32'd1);
    check("t5 zero busy", 32'(busy), 32'd0);
    check("t5 zero rd_en", 32'(bus.buf_rd_en), 32'd0);
    tick();
    check("t5 zero done pulse", 32'(done), 32'd0);
    check("t5 zero pops", 32'(pop_cnt - p0), 32'd0);
    check("t5 zero beats", 32'(beat_cnt - b0), 32'd0);
    mark();
    start = 1'b1; cfg_count = 16'd2;
    tick();
    start = 1'b0;
    repeat (2) tick();
    start = 1'b1; cfg_count = 16'd5;
    tick();
    start = 1'b0;
    wait_done("t5", 40);
    check_frame("t5", 1, 2, 32'h0000_7FFF, 32'hFFFF_8000, 32'd0, 32'd0);

    // Asynchronous reset mid-SEND, then a clean frame.
    push(32'h0002_0001);
    push(32'hFFFF_0003);
    mark();
    start = 1'b1; cfg_count = 16'd4;
    tick();
    start = 1'b0;
    repeat (2) tick();
    check("t6 in send", 32'(bus.out_valid), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("t6 rst valid", 32'(bus.out_valid), 32'd0);
    check("t6 rst busy", 32'(busy), 32'd0);
    check("t6 rst rd_en", 32'(bus.buf_rd_en), 32'd0);
    check("t6 rst done", 32'(done), 32'd0);
    check("t6 rst outData", bus.outData, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    tick();
    check("t6 no done on abort", 32'(done_cnt - d0), 32'd0);
    mark();
    start = 1'b1; cfg_count = 16'd2;
    tick();
    start = 1'b0;
    wait_done("t6", 40);
    check_frame("t6", 1, 2, 32'd3, 32'hFFFF_FFFF, 32'd0, 32'd0);

    check("no pop while empty", 32'(bad_pops), 32'd0);
    check("total done pulses", 32'(done_cnt), 32'd7);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
